serial_frame_rx: RTL and testbench

//  Asynchronous serial receiver feeding the debug/frame path. Recovers 9-bit frames from serial line rx
//  and presents each good frame as frame + a one-cycle frame_valid pulse (consumed directly by
//  the frame decoder and debug capture). Framing errors are flagged, never forwarded as valid data.

---
 rtl/serial_frame_rx.sv | 217 +++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Asynchronous serial receiver for the debug/frame path. Recovers frames of
// FRAME_BITS payload bits (LSB first) framed by one start bit (0) and one stop
// bit (1) from the idle-high line rx, oversampled at CLK_DIV clk cycles per bit.
// Each good frame is presented on frame together with a one-cycle frame_valid
// pulse. A frame whose stop bit samples low is discarded and reported with a
// one-cycle frame_err pulse; frame keeps its previous good value.
//
// Parameters
//   CLK_DIV     clk cycles per serial bit (>= 4, even)
//   FRAME_BITS  payload bits per frame
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   asynchronous, active-high reset
//   rx           in   serial line, idle high, asynchronous to clk
//   frame        out  last good frame received, held until the next good one
//   frame_valid  out  one-cycle pulse: frame has just been updated
//   frame_err    out  one-cycle pulse: stop bit sampled low, frame discarded
//   busy         out  high whenever the receiver FSM is not idle
//
// Timing
//   rx passes a 2-flop synchroniser; every decision uses the synchronised
//   copy rx_s. The start bit is re-checked half a bit after its falling edge,
//   so all later samples land near bit centres. frame_valid / frame_err rise
//   3 clk cycles after the mid-stop-bit point on rx (2 sync + 1 register).
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int CLK_DIV    = 16,
    parameter int FRAME_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    // -------------------------------------------------------------------------
    // Derived widths and compare points
    // -------------------------------------------------------------------------
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    // Half a bit after the start edge: centre of the start bit.
    localparam logic [CW-1:0] CNT_MID  = CW'(CLK_DIV / 2 - 1);
    // One full bit period: centre of the next bit.
    localparam logic [CW-1:0] CNT_END  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // Both stages reset to 1 so a reset never looks like a start bit.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // NOTE: sequential state is assigned with non-blocking (<=) so each flop
    // captures pre-edge values; blocking here would merge the two synchroniser
    // stages into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_next;
    logic [FRAME_BITS-1:0] frame_next;
    logic                  valid_next;
    logic                  err_next;

    // -------------------------------------------------------------------------
    // Next-state and datapath decode
    //
    // cnt free-runs inside START/DATA/STOP and is restarted at every sampling
    // point, so it always measures distance from the previous bit centre.
    // IDLE and RECOVER hold cnt at zero so START begins a clean half-bit count.
    // -------------------------------------------------------------------------
    // NOTE: every variable written here gets a default before the case, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        shift_next = shift_reg;
        frame_next = frame;
        valid_next = 1'b0;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                // Re-check at mid start bit: anything shorter than half a bit
                // is treated as a glitch and dropped silently.
                if (cnt == CNT_MID) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt == CNT_END) begin
                    cnt_next = '0;
                    // Payload arrives LSB first: bit idx lands at position idx.
                    for (int i = 0; i < FRAME_BITS; i++) begin
                        if (idx == IW'(i)) begin
                            shift_next[i] = rx_s;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end

            STOP: begin
                if (cnt == CNT_END) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        // Leaving at mid-stop lets a start bit that follows
                        // the stop bit directly be seen without any gap.
                        frame_next = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = RECOVER;
                    end
                end
            end

            RECOVER: begin
                // A held-low line (break) must not be mistaken for a new
                // start bit; wait for the line to return high first.
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            frame       <= frame_next;
            frame_valid <= valid_next;
            frame_err   <= err_next;
        end
    end

    // NOTE: the payload shift register is intentionally left without reset:
    // every bit is rewritten during DATA before STOP can copy it to frame, so
    // its power-up contents are never observable.
    always_ff @(posedge clk) begin
        shift_reg <= shift_next;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Directed bench for serial_frame_rx (CLK_DIV=16, FRAME_BITS=9). Four receiver
// instances share clk/rst; lane 0 runs the directed sequences, then all four
// lanes split the 512-value payload sweep between them. Inputs change on the
// falling clock edge and outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

    localparam int CLK_DIV    = 16;
    localparam int FRAME_BITS = 9;
    localparam int LANES      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                  rst;
    logic [LANES-1:0]                      rx_v;
    logic [LANES-1:0][FRAME_BITS-1:0]      frame_v;
    logic [LANES-1:0]                      valid_v;
    logic [LANES-1:0]                      err_v;
    logic [LANES-1:0]                      busy_v;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_frame_rx #(
            .CLK_DIV   (CLK_DIV),
            .FRAME_BITS(FRAME_BITS)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .rx         (rx_v[g]),
            .frame      (frame_v[g]),
            .frame_valid(valid_v[g]),
            .frame_err  (err_v[g]),
            .busy       (busy_v[g])
        );
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    int valid_cnt [LANES] = '{default: 0};
    int err_cnt   [LANES] = '{default: 0};
    int viol = 0;

    logic [LANES-1:0]                 prev_valid = '0;
    logic [LANES-1:0]                 prev_err   = '0;
    logic [LANES-1:0][FRAME_BITS-1:0] prev_frame = '0;

    // Pulse counter and protocol watcher: valid/err exclusive, never two
    // cycles in a row, and frame only moves together with frame_valid.
    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (rst) begin
                prev_valid[l] <= 1'b0;
                prev_err[l]   <= 1'b0;
                prev_frame[l] <= frame_v[l];
            end else begin
                if (valid_v[l]) valid_cnt[l] <= valid_cnt[l] + 1;
                if (err_v[l])   err_cnt[l]   <= err_cnt[l] + 1;
                if ((valid_v[l] && err_v[l]) ||
                    (valid_v[l] && prev_valid[l]) ||
                    (err_v[l] && prev_err[l]) ||
                    ((frame_v[l] != prev_frame[l]) && !valid_v[l])) begin
                    viol <= viol + 1;
                end
                prev_valid[l] <= valid_v[l];
                prev_err[l]   <= err_v[l];
                prev_frame[l] <= frame_v[l];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Line drivers
    // -------------------------------------------------------------------------
    task automatic send_bit(input int lane, input logic b, input int cycles);
        rx_v[lane] = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int lane, input logic [8:0] data, input logic stop,
                              input int stop_cycles);
        send_bit(lane, 1'b0, CLK_DIV);
        for (int i = 0; i < FRAME_BITS; i++) begin
            send_bit(lane, data[i], CLK_DIV);
        end
        send_bit(lane, stop, stop_cycles);
    endtask

    task automatic sweep(input int lane);
        for (int v = lane * 128; v < lane * 128 + 128; v++) begin
            logic [8:0] d;
            int         vc;
            d  = v[8:0];
            vc = valid_cnt[lane];
            send_frame(lane, d, 1'b1, CLK_DIV);
            check($sformatf("sweep_pulses_%0h", d), valid_cnt[lane] - vc, 1);
            check($sformatf("sweep_frame_%0h", d), frame_v[lane], d);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
    endtask

    // -------------------------------------------------------------------------
    // Table-driven single frames: {payload, stop bit, expected frame,
    // expected valid pulses, expected error pulses}
    // -------------------------------------------------------------------------
    typedef struct {
        logic [8:0] data;
        logic       stop;
        logic [8:0] exp_frame;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #800000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] d;
        int         vb;
        int         eb;
        int         eb_sweep[LANES];

        vecs[0] = '{9'h000, 1'b1, 9'h000, 1, 0};
        vecs[1] = '{9'h1FF, 1'b1, 9'h1FF, 1, 0};
        vecs[2] = '{9'h0AA, 1'b1, 9'h0AA, 1, 0};
        vecs[3] = '{9'h155, 1'b0, 9'h0AA, 0, 1};
        vecs[4] = '{9'h1C3, 1'b1, 9'h1C3, 1, 0};
        vecs[5] = '{9'h100, 1'b1, 9'h100, 1, 0};

        // ---- reset state ----
        rst  = 1'b1;
        rx_v = '1;
        repeat (3) @(negedge clk);
        check("reset_frame", frame_v[0], 0);
        check("reset_valid", valid_v[0], 0);
        check("reset_err",   err_v[0],   0);
        check("reset_busy",  busy_v,     0);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);

        // ---- 1: frame 1A5 with busy and exact pulse timing ----
        vb = valid_cnt[0];
        eb = err_cnt[0];
        d  = 9'h1A5;
        send_bit(0, 1'b0, 8);
        check("t1_busy_start", busy_v[0], 1);
        send_bit(0, 1'b0, 8);
        for (int i = 0; i < FRAME_BITS; i++) begin
            send_bit(0, d[i], 8);
            check($sformatf("t1_busy_bit%0d", i), busy_v[0], 1);
            send_bit(0, d[i], 8);
        end
        send_bit(0, 1'b1, 10);
        check("t1_valid_early", valid_v[0], 0);
        check("t1_busy_stop",   busy_v[0],  1);
        @(negedge clk);
        check("t1_valid_rise",  valid_v[0], 1);
        check("t1_frame",       frame_v[0], 9'h1A5);
        check("t1_busy_after",  busy_v[0],  0);
        @(negedge clk);
        check("t1_valid_fall",  valid_v[0], 0);
        repeat (8) @(negedge clk);
        check("t1_pulses", valid_cnt[0] - vb, 1);
        check("t1_errs",   err_cnt[0] - eb,   0);

        // ---- table of single frames ----
        for (int k = 0; k < 6; k++) begin
            vb = valid_cnt[0];
            eb = err_cnt[0];
            send_frame(0, vecs[k].data, vecs[k].stop, CLK_DIV);
            rx_v[0] = 1'b1;
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_frame", k), frame_v[0], vecs[k].exp_frame);
            check($sformatf("vec%0d_valid", k), valid_cnt[0] - vb, vecs[k].exp_valid);
            check($sformatf("vec%0d_err", k),   err_cnt[0] - eb,   vecs[k].exp_err);
            check($sformatf("vec%0d_busy", k),  busy_v[0], 0);
        end

        // ---- 2: 4-cycle glitch in IDLE ----
        vb = valid_cnt[0];
        eb = err_cnt[0];
        send_bit(0, 1'b0, 4);
        send_bit(0, 1'b1, 1);
        check("t2_busy_glitch", busy_v[0], 1);
        repeat (20) @(negedge clk);
        check("t2_busy_after", busy_v[0], 0);
        check("t2_valid",      valid_cnt[0] - vb, 0);
        check("t2_err",        err_cnt[0] - eb,   0);
        check("t2_frame",      frame_v[0], 9'h100);

        // ---- 3: bad stop bit followed by a long break ----
        send_frame(0, 9'h0FF, 1'b1, CLK_DIV);
        check("t3_frame_good", frame_v[0], 9'h0FF);
        vb = valid_cnt[0];
        eb = err_cnt[0];
        send_frame(0, 9'h100, 1'b0, CLK_DIV);
        send_bit(0, 1'b0, 200);
        check("t3_err",        err_cnt[0] - eb,   1);
        check("t3_valid",      valid_cnt[0] - vb, 0);
        check("t3_frame_held", frame_v[0], 9'h0FF);
        check("t3_busy_break", busy_v[0], 1);
        send_bit(0, 1'b1, 6);
        check("t3_busy_idle",  busy_v[0], 0);
        check("t3_err_once",   err_cnt[0] - eb, 1);

        // ---- 4: back-to-back frames, no idle gap ----
        vb = valid_cnt[0];
        send_frame(0, 9'h001, 1'b1, CLK_DIV);
        check("t4_frame_a", frame_v[0], 9'h001);
        check("t4_count_a", valid_cnt[0] - vb, 1);
        send_frame(0, 9'h1FE, 1'b1, CLK_DIV);
        check("t4_frame_b", frame_v[0], 9'h1FE);
        check("t4_count_b", valid_cnt[0] - vb, 2);
        repeat (4) @(negedge clk);

        // ---- 5: reset during payload bit 4 ----
        vb = valid_cnt[0];
        eb = err_cnt[0];
        d  = 9'h1B6;
        send_bit(0, 1'b0, CLK_DIV);
        for (int i = 0; i < 4; i++) begin
            send_bit(0, d[i], CLK_DIV);
        end
        send_bit(0, d[4], 8);
        #1 rst = 1'b1;
        rx_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_frame", frame_v[0], 0);
        check("t5_rst_valid", valid_v[0], 0);
        check("t5_rst_err",   err_v[0],   0);
        check("t5_rst_busy",  busy_v[0],  0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (CLK_DIV * 6) @(negedge clk);
        check("t5_no_pulse",  valid_cnt[0] - vb, 0);
        check("t5_no_err",    err_cnt[0] - eb,   0);
        check("t5_busy_idle", busy_v[0], 0);
        send_frame(0, 9'h055, 1'b1, CLK_DIV);
        repeat (4) @(negedge clk);
        check("t5_frame", frame_v[0], 9'h055);
        check("t5_count", valid_cnt[0] - vb, 1);

        // ---- 6: sweep all payloads across the four lanes ----
        for (int l = 0; l < LANES; l++) eb_sweep[l] = err_cnt[l];
        for (int l = 0; l < LANES; l++) begin
            automatic int ln = l;
            fork
                sweep(ln);
            join_none
        end
        wait fork;
        repeat (4) @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            check($sformatf("sweep_err_lane%0d", l), err_cnt[l] - eb_sweep[l], 0);
        end
        check("protocol_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
